alu_serial_ctrl: RTL and testbench
==================================

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001: Clock  input  1  sole clock; all state updates on rising edge.
REQ-002: Reset  input  1  asynchronous, active-high; forces reset state immediately, independent of Clock.
REQ-003: Start  input  1  request to begin an operation; sampled only in IDLE.
REQ-004: Op  input  3  operation code; captured on accepted Start.
REQ-005: A  input  16  operand A; captured on accepted Start.
REQ-006: B  input  16  operand B; captured on accepted Start.
REQ-007: S  output  3  result-mux select driven to the 1-bit ALU slice: captured Op during RUN, 000 otherwise.
REQ-008: BitIndex  output  4  bit position being processed during RUN (0..15); 0 otherwise.
REQ-009: Busy  output  1  high in RUN and DONE.
REQ-010: Done  output  1  one-cycle pulse when Result and flags are valid.
REQ-011: Result  output  16  operation result.
REQ-012: CarryOut  output  1  final carry out of bit 15; add/sub only.
REQ-013: Overflow  output  1  signed overflow; add/sub only.
REQ-014: Zero  output  1  high when Result == 0x0000.

Function
REQ-015: Op decode SHALL follow the slice mux: 000/001 AND, 010 OR, 011 XOR, 100/101 ADD, 110/111 SUB (A + ~B + 1).
REQ-016: States SHALL be IDLE, RUN, DONE; no other reachable state.
REQ-017: IDLE with Start=1 at edge E0: capture A, B, Op; BitIndex=0; carry flop = 1 for SUB, 0 otherwise; go to RUN.
REQ-018: IDLE with Start=0: remain in IDLE; all outputs hold.
REQ-019: Each RUN edge SHALL compute bit BitIndex of the captured operation, shift it into Result LSB-first (bit i lands in Result[i]), update carry flop (add/sub), increment BitIndex.
REQ-020: The edge processing bit 15 (E16) SHALL move to DONE, update CarryOut, Overflow, Zero, and raise Done; Start-edge-to-Done latency is exactly 16 cycles.
REQ-021: Overflow SHALL equal carry into bit 15 XOR carry out of bit 15 for ADD/SUB; 0 for logic ops.
REQ-022: CarryOut SHALL be 0 for logic ops; for SUB, CarryOut=1 means no borrow.
REQ-023: DONE SHALL last exactly one cycle, then IDLE unconditionally; Done low in all other states.
REQ-024: Start in RUN or DONE SHALL be ignored; A, B, Op changes after capture SHALL NOT affect the running operation.
REQ-025: Result, CarryOut, Overflow, Zero SHALL hold their values from DONE until the next accepted Start; partial Result bits are visible during RUN, but flags stay unchanged until E16.
REQ-026: BitIndex SHALL never wrap during RUN; value 15 always leads to DONE.

Reset
REQ-027: While Reset=1: state IDLE, Busy=0, Done=0, S=000, BitIndex=0, Result=0x0000, CarryOut=0, Overflow=0, Zero=1, carry flop=0.
REQ-028: Reset asserted mid-RUN or in DONE SHALL abort the operation with no Done pulse; first Start after deassertion SHALL be accepted normally.
REQ-029: Start high on the first edge after Reset deassertion SHALL be accepted.

Verification
REQ-030: ADD A=0x7FFF B=0x0001 -> Done 16 cycles after Start edge; Result=0x8000, Overflow=1, CarryOut=0, Zero=0.
REQ-031: ADD A=0xFFFF B=0x0001 -> Result=0x0000, CarryOut=1, Overflow=0, Zero=1.
REQ-032: SUB (110) A=0x0005 B=0x0005 -> Result=0x0000, CarryOut=1, Zero=1; SUB A=0x0003 B=0x0005 -> Result=0xFFFE, CarryOut=0.
REQ-033: XOR (011) A=0xFF00 B=0x0FF0 -> Result=0xF0F0, CarryOut=0, Overflow=0; op 001 with A=0x00FF B=0x0F0F -> Result=0x000F (AND).
REQ-034: Start held high through RUN with A, B changed every cycle -> single Done, Result from captured operands, next op starts only after return to IDLE.
REQ-035: Reset pulsed with BitIndex=7 -> all outputs at reset values immediately, no Done; subsequent ADD 0x0001+0x0001 -> Result=0x0002 after 16 cycles.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: captures a 16-bit operation on Start, runs one
// 1-bit ALU slice per clock LSB-first, then presents Result and flags.
module alu_serial_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [2:0]  s,
    output logic [3:0]  bit_index,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry_out,
    output logic        overflow,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic [2:0]  op_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic        carry_r;
    logic [2:0]  s_r;
    logic [3:0]  bit_index_r;
    logic        busy_r;
    logic        done_r;
    logic [15:0] result_r;
    logic        carry_out_r;
    logic        overflow_r;
    logic        zero_r;

    logic [1:0]  slice_s;
    logic        is_arith_s;
    logic        last_bit_s;
    logic [15:0] final_result_s;

    // One ALU slice: returns {carry_out, result_bit}; SUB is A + ~B with carry-in 1.
    function automatic logic [1:0] alu_slice(
        input logic [2:0] sel,
        input logic       ai,
        input logic       bi,
        input logic       ci
    );
        logic [1:0] res;
        logic       bx;
        res = 2'b00;
        bx  = ~bi;
        case (sel)
            3'b000, 3'b001: res = {1'b0, ai & bi};
            3'b010:         res = {1'b0, ai | bi};
            3'b011:         res = {1'b0, ai ^ bi};
            3'b100, 3'b101: res = {(ai & bi) | (ai & ci) | (bi & ci), ai ^ bi ^ ci};
            3'b110, 3'b111: res = {(ai & bx) | (ai & ci) | (bx & ci), ai ^ bx ^ ci};
            default:        res = 2'b00;
        endcase
        return res;
    endfunction

    assign slice_s        = alu_slice(op_r, a_r[bit_index_r], b_r[bit_index_r], carry_r);
    assign is_arith_s     = op_r[2];
    assign last_bit_s     = (bit_index_r == 4'd15);
    assign final_result_s = {slice_s[0], result_r[14:0]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; DONE always falls back to IDLE after one cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Operand capture, serial datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r        <= 3'b000;
            a_r         <= 16'h0000;
            b_r         <= 16'h0000;
            carry_r     <= 1'b0;
            s_r         <= 3'b000;
            bit_index_r <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= 16'h0000;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r        <= op;
                        a_r         <= a;
                        b_r         <= b;
                        carry_r     <= (op[2:1] == 2'b11);
                        s_r         <= op;
                        bit_index_r <= 4'd0;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                    end
                end
                RUN: begin
                    result_r[bit_index_r] <= slice_s[0];
                    if (is_arith_s) begin
                        carry_r <= slice_s[1];
                    end
                    if (last_bit_s) begin
                        // Flags only change here, so they hold through RUN.
                        s_r         <= 3'b000;
                        bit_index_r <= 4'd0;
                        done_r      <= 1'b1;
                        carry_out_r <= is_arith_s ? slice_s[1] : 1'b0;
                        overflow_r  <= is_arith_s ? (carry_r ^ slice_s[1]) : 1'b0;
                        zero_r      <= (final_result_s == 16'h0000);
                    end else begin
                        bit_index_r <= bit_index_r + 4'd1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    s_r         <= 3'b000;
                    bit_index_r <= 4'd0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign s         = s_r;
    assign bit_index = bit_index_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: directed corner cases plus random
// operations compared against a word-level arithmetic reference model.
module tb_alu_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic [2:0]  s;
    logic [3:0]  bit_index;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    int vectors = 0;
    int errors  = 0;

    // Values the outputs must hold between operations.
    logic [15:0] exp_res = 16'h0000;
    logic        exp_c   = 1'b0;
    logic        exp_v   = 1'b0;
    logic        exp_z   = 1'b1;

    alu_serial_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .s(s), .bit_index(bit_index), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    // Word-level reference: returns {carry, overflow, result}.
    function automatic logic [17:0] model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s17;
        logic [15:0] r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        r = 16'h0000;
        case (o[2:1])
            2'b00: r = x & y;
            2'b01: r = o[0] ? (x ^ y) : (x | y);
            2'b10: begin
                s17 = {1'b0, x} + {1'b0, y};
                r = s17[15:0];
                c = s17[16];
                v = (x[15] == y[15]) && (r[15] != x[15]);
            end
            default: begin
                s17 = {1'b0, x} + {1'b0, ~y} + 17'd1;
                r = s17[15:0];
                c = s17[16];
                v = (x[15] != y[15]) && (r[15] != x[15]);
            end
        endcase
        return {c, v, r};
    endfunction

    // Runs one operation from IDLE (called #1 after a rising edge).
    task automatic do_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                         input bit scramble, input bit hold_start);
        logic [17:0] m;
        int n;
        bit seen;
        m = model(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || s !== o || bit_index !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL capture: busy=%b s=%b idx=%0d done=%b, required busy=1 s=%b idx=0 done=0", busy, s, bit_index, done, o);
        end
        seen = 0;
        n = 0;
        while (!seen && n < 40) begin
            if (scramble) begin
                a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
            end
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) begin
                seen = 1;
            end else if (n < 16) begin
                vectors++;
                if (bit_index !== n[3:0] || s !== o || busy !== 1'b1 ||
                    carry_out !== exp_c || overflow !== exp_v || zero !== exp_z) begin
                    errors++;
                    $display("FAIL run cycle %0d: idx=%0d s=%b busy=%b c=%b v=%b z=%b, required idx=%0d s=%b busy=1 c=%b v=%b z=%b",
                             n, bit_index, s, busy, carry_out, overflow, zero, n, o, exp_c, exp_v, exp_z);
                end
            end
        end
        vectors++;
        if (!seen || n != 16) begin
            errors++;
            $display("FAIL latency: done after %0d cycles (seen=%0d), required 16", n, seen);
        end
        vectors++;
        if (result !== m[15:0] || carry_out !== m[17] || overflow !== m[16] ||
            zero !== (m[15:0] == 16'h0000) || busy !== 1'b1 || s !== 3'b000 || bit_index !== 4'd0) begin
            errors++;
            $display("FAIL result op=%b a=%h b=%h: res=%h c=%b v=%b z=%b busy=%b s=%b idx=%0d, required res=%h c=%b v=%b z=%b busy=1 s=0 idx=0",
                     o, x, y, result, carry_out, overflow, zero, busy, s, bit_index,
                     m[15:0], m[17], m[16], (m[15:0] == 16'h0000));
        end
        exp_res = m[15:0];
        exp_c   = m[17];
        exp_v   = m[16];
        exp_z   = (m[15:0] == 16'h0000);
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res ||
            carry_out !== exp_c || overflow !== exp_v || zero !== exp_z) begin
            errors++;
            $display("FAIL after_done: done=%b busy=%b res=%h c=%b v=%b z=%b, required done=0 busy=0 res=%h c=%b v=%b z=%b",
                     done, busy, result, carry_out, overflow, zero, exp_res, exp_c, exp_v, exp_z);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 3'b000 || bit_index !== 4'd0 ||
            result !== 16'h0000 || carry_out !== 1'b0 || overflow !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b s=%b idx=%0d res=%h c=%b v=%b z=%b, required 0 0 000 0 0000 0 0 1",
                     busy, done, s, bit_index, result, carry_out, overflow, zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        do_op(3'b100, 16'h7FFF, 16'h0001, 0, 0);
        vectors++;
        if (result !== 16'h8000 || overflow !== 1'b1 || carry_out !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL add_ovf: res=%h v=%b c=%b z=%b, required 8000 1 0 0", result, overflow, carry_out, zero);
        end
        do_op(3'b100, 16'hFFFF, 16'h0001, 0, 0);
        vectors++;
        if (result !== 16'h0000 || carry_out !== 1'b1 || overflow !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap: res=%h c=%b v=%b z=%b, required 0000 1 0 1", result, carry_out, overflow, zero);
        end
        do_op(3'b110, 16'h0005, 16'h0005, 0, 0);
        do_op(3'b110, 16'h0003, 16'h0005, 0, 0);
        vectors++;
        if (result !== 16'hFFFE || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: res=%h c=%b, required FFFE 0", result, carry_out);
        end
        do_op(3'b011, 16'hFF00, 16'h0FF0, 0, 0);
        do_op(3'b001, 16'h00FF, 16'h0F0F, 0, 0);
        vectors++;
        if (result !== 16'h000F) begin
            errors++;
            $display("FAIL and_op001: res=%h, required 000F", result);
        end
        do_op(3'b010, 16'hA5A5, 16'h0F0F, 0, 0);
        do_op(3'b111, 16'h8000, 16'h0001, 0, 0);
    endtask

    task automatic test_start_held();
        // Start stays high and operands churn; second op must wait for IDLE.
        do_op(3'b101, 16'h1234, 16'h4321, 1, 1);
        do_op(3'b110, 16'h0100, 16'h0001, 1, 1);
        start = 1'b0;
    endtask

    task automatic test_reset_midrun();
        start = 1'b1; op = 3'b100; a = 16'h1234; b = 16'h1111;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (bit_index !== 4'd7) begin
            errors++;
            $display("FAIL midrun_index: idx=%0d, required 7", bit_index);
        end
        #2 rst = 1'b1;
        #1;
        exp_res = 16'h0000; exp_c = 1'b0; exp_v = 1'b0; exp_z = 1'b1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 3'b000 || bit_index !== 4'd0 ||
            result !== 16'h0000 || carry_out !== 1'b0 || overflow !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b s=%b idx=%0d res=%h c=%b v=%b z=%b, required 0 0 000 0 0000 0 0 1",
                     busy, done, s, bit_index, result, carry_out, overflow, zero);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i == 11) rst = 1'b0;
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done cycle %0d: done=%b busy=%b, required 0 0", i, done, busy);
            end
        end
        do_op(3'b100, 16'h0001, 16'h0001, 0, 0);
        vectors++;
        if (result !== 16'h0002) begin
            errors++;
            $display("FAIL post_reset_add: res=%h, required 0002", result);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            do_op(3'($urandom), 16'($urandom), 16'($urandom), bit'($urandom_range(0, 1)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_held();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
